// File: rtl/me_result_deser.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : me_result_deser
// Purpose  : Rebuilds serial20 result frames from the motion-estimation chip,
//            splits them into motion vector / SAD and buffers them in a
//            2-entry first-word fall-through FIFO.
// Revision : 1.0  initial release
// ============================================================================
module me_result_deser #(
    parameter int RESULT_WIDTH = 20,
    parameter int MV_WIDTH     = 4,
    parameter int SAD_WIDTH    = 12,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 err_clr,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [MV_WIDTH-1:0]  out_mv_x,
    output logic [MV_WIDTH-1:0]  out_mv_y,
    output logic [SAD_WIDTH-1:0] out_sad,
    output logic                 frame_err,
    output logic                 ovf_err,
    output logic [CNT_WIDTH-1:0] word_cnt
);

    localparam int c_bcw = $clog2(RESULT_WIDTH);
    localparam logic [c_bcw-1:0] c_last_bit = c_bcw'(RESULT_WIDTH - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_data = 2'd1;
    localparam logic [1:0] c_stop = 2'd2;

    logic [1:0]              r_state;
    logic [c_bcw-1:0]        r_bit_cnt;
    logic [RESULT_WIDTH-1:0] r_shift;

    logic [RESULT_WIDTH-1:0] r_mem [0:1];
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [1:0]              r_count;
    logic                    r_frame_err;
    logic                    r_ovf_err;
    logic [CNT_WIDTH-1:0]    r_word_cnt;

    logic                    w_push_req;
    logic                    w_frame_evt;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_ovf_evt;
    logic [RESULT_WIDTH-1:0] w_head;

    // Line receiver: start 1, RESULT_WIDTH data bits MSB first, stop 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_idle;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (serial_in) begin
                        r_state   <= c_data;
                        r_bit_cnt <= '0;
                    end
                end
                c_data: begin
                    r_shift <= {r_shift[RESULT_WIDTH-2:0], serial_in};
                    if (r_bit_cnt == c_last_bit) begin
                        r_state <= c_stop;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + c_bcw'(1);
                    end
                end
                c_stop: begin
                    // A 1 here is a framing error, never a new start bit
                    r_state <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign w_push_req  = (r_state == c_stop) && !serial_in;
    assign w_frame_evt = (r_state == c_stop) &&  serial_in;
    assign w_full      = (r_count == 2'd2);
    assign out_valid   = (r_count != 2'd0);
    assign w_pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot for the incoming word
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_ovf_evt   = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
            r_ovf_err   <= 1'b0;
            r_word_cnt  <= '0;
        end else begin
            if (w_frame_evt)  r_frame_err <= 1'b1;
            else if (err_clr) r_frame_err <= 1'b0;

            if (w_ovf_evt)    r_ovf_err <= 1'b1;
            else if (err_clr) r_ovf_err <= 1'b0;

            if (w_push)       r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign out_mv_x  = w_head[RESULT_WIDTH-1 -: MV_WIDTH];
    assign out_mv_y  = w_head[RESULT_WIDTH-MV_WIDTH-1 -: MV_WIDTH];
    assign out_sad   = w_head[SAD_WIDTH-1:0];
    assign frame_err = r_frame_err;
    assign ovf_err   = r_ovf_err;
    assign word_cnt  = r_word_cnt;

endmodule
`default_nettype wire
